apb_bridge_decoder: RTL and testbench

//  Registered APB3 fabric stage: one upstream APB master port, NUM_SLV downstream APB slave ports.

---
 rtl/apb_bridge_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_apb_bridge_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_decoder.sv
// Registered APB3 fabric stage: one upstream master port decoded onto NUM_SLV
// downstream slave ports. Unmapped addresses and slaves that stall past the
// timeout are answered locally with PSLVERR.
module apb_bridge_decoder #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned NUM_SLV        = 4,
  parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int unsigned TIMEOUT        = 256
) (
  input  logic                              pclk,
  input  logic                              preset,
  // upstream master side
  input  logic [APB_ADDR_WIDTH-1:0]         m_paddr,
  input  logic [APB_DATA_WIDTH-1:0]         m_pwdata,
  input  logic                              m_pwrite,
  input  logic                              m_psel,
  input  logic                              m_penable,
  output logic [APB_DATA_WIDTH-1:0]         m_prdata,
  output logic                              m_pready,
  output logic                              m_pslverr,
  // downstream slave side
  output logic [APB_ADDR_WIDTH-1:0]         s_paddr,
  output logic [APB_DATA_WIDTH-1:0]         s_pwdata,
  output logic                              s_pwrite,
  output logic [NUM_SLV-1:0]                s_psel,
  output logic                              s_penable,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] s_prdata,
  input  logic [NUM_SLV-1:0]                s_pready,
  input  logic [NUM_SLV-1:0]                s_pslverr
);

  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam int unsigned DW = APB_DATA_WIDTH;
  localparam int unsigned IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]      paddr_d;
  logic [DW-1:0]      pwdata_d;
  logic               pwrite_d;
  logic [NUM_SLV-1:0] psel_d;
  logic               penable_d;
  logic [DW-1:0]      prdata_d;
  logic               pready_d;
  logic               pslverr_d;

  logic [NUM_SLV-1:0] match;
  logic               hit;
  logic [IW-1:0]      hit_idx;
  logic [NUM_SLV-1:0] hit_onehot;

  logic [DW-1:0]      sel_rdata;
  logic               sel_ready;
  logic               sel_err;
  logic               timeout_hit;

  // Address decode of the live upstream address; lowest matching index wins.
  always_comb begin
    match      = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      match[i] = ((m_paddr & SLV_MASK[i*AW +: AW]) ==
                  (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
    end
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (match[i] && !hit) begin
        hit           = 1'b1;
        hit_idx       = IW'(i);
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // Response mux for the slave latched at setup time.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_rdata = s_prdata[i*DW +: DW];
        sel_ready = s_pready[i];
        sel_err   = s_pslverr[i];
      end
    end
  end

  // Wait-state limit reached on this ACCESS cycle (never when TIMEOUT is 0).
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);
  end

  // Next-state and next-output logic; every registered output has a default.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    paddr_d   = s_paddr;
    pwdata_d  = s_pwdata;
    pwrite_d  = s_pwrite;
    psel_d    = s_psel;
    penable_d = s_penable;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_psel && !m_penable) begin
          paddr_d  = m_paddr;
          pwdata_d = m_pwdata;
          pwrite_d = m_pwrite;
          if (hit) begin
            state_d = SETUP;
            idx_d   = hit_idx;
            psel_d  = hit_onehot;
          end else begin
            // Unmapped: answer locally on the next cycle.
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = sel_err;
          prdata_d  = s_pwrite ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d   = RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (TIMEOUT > 0) begin
          // Cannot wrap: the timeout fires at TIMEOUT-1 < 2**CW - 1.
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      s_paddr   <= '0;
      s_pwdata  <= '0;
      s_pwrite  <= 1'b0;
      s_psel    <= '0;
      s_penable <= 1'b0;
      m_prdata  <= '0;
      m_pready  <= 1'b0;
      m_pslverr <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      s_paddr   <= paddr_d;
      s_pwdata  <= pwdata_d;
      s_pwrite  <= pwrite_d;
      s_psel    <= psel_d;
      s_penable <= penable_d;
      m_prdata  <= prdata_d;
      m_pready  <= pready_d;
      m_pslverr <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_apb_bridge_decoder.sv
// Bench for apb_bridge_decoder: directed vector table, hand-written reset and
// overlap sequences, and randomized transfers against a transaction-level model.
module tb_apb_bridge_decoder;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int          TO = 8;
  localparam int          MAXCYC = 40;

  localparam logic [NS*AW-1:0] MAIN_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] OV_BASE   = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] ALL_MASK  = {4{32'hF000_0000}};
  localparam logic [31:0] REF_BASE [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  localparam logic [31:0] REF_MASK = 32'hF000_0000;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  // main instance
  logic              preset;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic              m_pwrite, m_psel, m_penable;
  logic [DW-1:0]     m_prdata;
  logic              m_pready, m_pslverr;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic              s_pwrite;
  logic [NS-1:0]     s_psel;
  logic              s_penable;
  logic [NS*DW-1:0]  s_prdata;
  logic [NS-1:0]     s_pready, s_pslverr;

  // overlapping-map instance
  logic              ov_preset;
  logic [AW-1:0]     ov_m_paddr;
  logic [DW-1:0]     ov_m_pwdata;
  logic              ov_m_pwrite, ov_m_psel, ov_m_penable;
  logic [DW-1:0]     ov_m_prdata;
  logic              ov_m_pready, ov_m_pslverr;
  logic [AW-1:0]     ov_s_paddr;
  logic [DW-1:0]     ov_s_pwdata;
  logic              ov_s_pwrite;
  logic [NS-1:0]     ov_s_psel;
  logic              ov_s_penable;
  logic [NS*DW-1:0]  ov_s_prdata;
  logic [NS-1:0]     ov_s_pready, ov_s_pslverr;

  apb_bridge_decoder #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_SLV(NS),
    .SLV_BASE(MAIN_BASE), .SLV_MASK(ALL_MASK), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
    .s_psel(s_psel), .s_penable(s_penable),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
  );

  apb_bridge_decoder #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_SLV(NS),
    .SLV_BASE(OV_BASE), .SLV_MASK(ALL_MASK), .TIMEOUT(TO)
  ) dut_ov (
    .pclk(pclk), .preset(ov_preset),
    .m_paddr(ov_m_paddr), .m_pwdata(ov_m_pwdata), .m_pwrite(ov_m_pwrite),
    .m_psel(ov_m_psel), .m_penable(ov_m_penable),
    .m_prdata(ov_m_prdata), .m_pready(ov_m_pready), .m_pslverr(ov_m_pslverr),
    .s_paddr(ov_s_paddr), .s_pwdata(ov_s_pwdata), .s_pwrite(ov_s_pwrite),
    .s_psel(ov_s_psel), .s_penable(ov_s_penable),
    .s_prdata(ov_s_prdata), .s_pready(ov_s_pready), .s_pslverr(ov_s_pslverr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Transaction-level reference: which slave, how long, what comes back.
  function automatic void model(input logic [31:0] addr, input bit wr, input int waits,
                                input logic [31:0] sd, input bit se,
                                output int lat, output logic [3:0] psel, output bit err,
                                output logic [31:0] rd, output int pen);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (idx < 0 && (addr & REF_MASK) == (REF_BASE[i] & REF_MASK)) idx = i;
    if (idx < 0) begin
      lat = 1; psel = 4'b0000; err = 1'b1; rd = 32'h0; pen = 0;
    end else if (waits >= TO) begin
      lat = 2 + TO; psel = 4'(1 << idx); err = 1'b1; rd = 32'h0; pen = TO;
    end else begin
      lat = 3 + waits; psel = 4'(1 << idx); err = se; rd = wr ? 32'h0 : sd; pen = waits + 1;
    end
  endfunction

  function automatic int onehot_idx(input logic [3:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // observations from the last transfer
  int          r_lat, r_pen;
  bit          r_seen;
  logic        r_err, r_pen1, r_pwrite1;
  logic [31:0] r_rd, r_paddr1, r_pwdata1;
  logic [3:0]  r_psel1, r_psel_or;

  // Drive one upstream transfer starting now (an IDLE-state cycle) and act as
  // the selected slave with `waits` wait states. Returns in the cycle after RESP.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                          input int waits, input logic [31:0] sdata, input bit serr,
                          input bit drop, input bit scramble, input int data_idx);
    int acc;
    acc = 0;
    r_seen = 1'b0; r_lat = 0; r_psel_or = '0; r_err = 1'b0; r_rd = '0;
    r_psel1 = '0; r_pen1 = 1'b0; r_paddr1 = '0; r_pwdata1 = '0; r_pwrite1 = 1'b0;
    for (int i = 0; i < NS; i++) s_prdata[i*DW +: DW] = (i == data_idx) ? sdata : ~sdata;
    s_pready  = '1;
    s_pslverr = {NS{~serr}};
    m_paddr = addr; m_pwdata = wdata; m_pwrite = wr; m_psel = 1'b1; m_penable = 1'b0;
    for (int cyc = 1; cyc <= MAXCYC; cyc++) begin
      step();
      if (cyc == 1) begin
        r_psel1 = s_psel; r_pen1 = s_penable; r_paddr1 = s_paddr;
        r_pwdata1 = s_pwdata; r_pwrite1 = s_pwrite;
      end
      r_psel_or = r_psel_or | s_psel;
      if (m_pready) begin
        r_seen = 1'b1; r_lat = cyc; r_err = m_pslverr; r_rd = m_prdata;
        break;
      end
      for (int i = 0; i < NS; i++) begin
        if (s_psel[i]) begin
          s_pready[i]  = s_penable && (acc >= waits);
          s_pslverr[i] = serr;
        end else begin
          s_pready[i]  = 1'b1;
          s_pslverr[i] = ~serr;
        end
      end
      if (s_penable) acc++;
      if (drop) begin
        m_psel = 1'b0; m_penable = 1'b0;
      end else begin
        m_penable = 1'b1;
      end
      if (scramble) begin
        m_paddr = $urandom; m_pwdata = $urandom; m_pwrite = 1'($urandom_range(0, 1));
      end
    end
    r_pen = acc;
    step();
    check("pready_single_pulse", 32'(m_pready), 32'h0);
    check("psel_idle_after_resp", 32'(s_psel), 32'h0);
    m_psel = 1'b0; m_penable = 1'b0;
  endtask

  task automatic check_xfer(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit wr, input int lat, input logic [3:0] psel, input bit err,
                            input logic [31:0] rd, input int pen);
    check({tag, "_pready_seen"}, 32'(r_seen), 32'h1);
    check({tag, "_latency"}, 32'(r_lat), 32'(lat));
    check({tag, "_pslverr"}, 32'(r_err), 32'(err));
    check({tag, "_prdata"}, r_rd, rd);
    check({tag, "_psel_T1"}, 32'(r_psel1), 32'(psel));
    check({tag, "_penable_T1"}, 32'(r_pen1), 32'h0);
    check({tag, "_psel_during"}, 32'(r_psel_or), 32'(psel));
    check({tag, "_penable_cycles"}, 32'(r_pen), 32'(pen));
    check({tag, "_paddr"}, r_paddr1, addr);
    check({tag, "_pwdata"}, r_pwdata1, wdata);
    check({tag, "_pwrite"}, 32'(r_pwrite1), 32'(wr));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    int          waits;
    logic [31:0] sdata;
    bit          serr;
    bit          drop;
    int          lat;
    logic [3:0]  psel;
    bit          err;
    logic [31:0] rd;
    int          pen;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [3:0] nibs [6];
    int m_lat, m_pen;
    logic [3:0] m_psel_e;
    bit m_err;
    logic [31:0] m_rd;
    int pulses, sel_seen;

    // addr, wdata, wr, waits, sdata, serr, drop | lat, psel, err, rdata, penable cycles
    vecs[0]  = '{32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 0,  32'h0000_0000, 1'b0, 1'b0, 3,  4'b0010, 1'b0, 32'h0000_0000, 1};
    vecs[1]  = '{32'h2000_0010, 32'h0000_0000, 1'b0, 3,  32'h1234_5678, 1'b0, 1'b0, 6,  4'b0100, 1'b0, 32'h1234_5678, 4};
    vecs[2]  = '{32'hF000_0000, 32'h0000_0000, 1'b0, 0,  32'h0BAD_0BAD, 1'b0, 1'b0, 1,  4'b0000, 1'b1, 32'h0000_0000, 0};
    vecs[3]  = '{32'h0000_0100, 32'h0000_0000, 1'b0, 20, 32'hCAFE_0000, 1'b0, 1'b0, 10, 4'b0001, 1'b1, 32'h0000_0000, 8};
    vecs[4]  = '{32'h0000_0200, 32'h0000_0000, 1'b0, 0,  32'hAAAA_5555, 1'b0, 1'b0, 3,  4'b0001, 1'b0, 32'hAAAA_5555, 1};
    vecs[5]  = '{32'h3000_0000, 32'h0000_0000, 1'b0, 1,  32'h0000_1111, 1'b1, 1'b0, 4,  4'b1000, 1'b1, 32'h0000_1111, 2};
    vecs[6]  = '{32'h3000_0008, 32'h0BAD_F00D, 1'b1, 2,  32'h9999_9999, 1'b0, 1'b0, 5,  4'b1000, 1'b0, 32'h0000_0000, 3};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 7,  32'h7777_7777, 1'b0, 1'b0, 10, 4'b0001, 1'b0, 32'h7777_7777, 8};
    vecs[8]  = '{32'h5000_0000, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 1'b0, 1'b0, 1,  4'b0000, 1'b1, 32'h0000_0000, 0};
    vecs[9]  = '{32'h2000_0000, 32'h1111_2222, 1'b1, 8,  32'h0000_0000, 1'b0, 1'b0, 10, 4'b0100, 1'b1, 32'h0000_0000, 8};
    vecs[10] = '{32'h2000_0020, 32'h0000_0000, 1'b0, 2,  32'h5A5A_5A5A, 1'b0, 1'b1, 5,  4'b0100, 1'b0, 32'h5A5A_5A5A, 3};

    nibs[0] = 4'h0; nibs[1] = 4'h1; nibs[2] = 4'h2;
    nibs[3] = 4'h3; nibs[4] = 4'h4; nibs[5] = 4'hF;

    // ---- reset: held for two cycles with a setup pending on the bus ----
    preset = 1'b1; ov_preset = 1'b1;
    m_paddr = 32'h1000_0000; m_pwdata = 32'h5555_AAAA; m_pwrite = 1'b1;
    m_psel = 1'b1; m_penable = 1'b0;
    s_prdata = '0; s_pready = '1; s_pslverr = '0;
    ov_m_paddr = '0; ov_m_pwdata = '0; ov_m_pwrite = 1'b0; ov_m_psel = 1'b0; ov_m_penable = 1'b0;
    ov_s_prdata = '0; ov_s_pready = '0; ov_s_pslverr = '0;
    step();
    step();
    check("rst_m_pready", 32'(m_pready), 32'h0);
    check("rst_m_pslverr", 32'(m_pslverr), 32'h0);
    check("rst_m_prdata", m_prdata, 32'h0);
    check("rst_s_psel", 32'(s_psel), 32'h0);
    check("rst_s_penable", 32'(s_penable), 32'h0);
    check("rst_s_paddr", s_paddr, 32'h0);
    check("rst_s_pwdata", s_pwdata, 32'h0);
    check("rst_s_pwrite", 32'(s_pwrite), 32'h0);
    preset = 1'b0; ov_preset = 1'b0; m_psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_s_psel", 32'(s_psel), 32'h0);
      check("post_rst_m_pready", 32'(m_pready), 32'h0);
    end

    // ---- directed vector table, applied back-to-back ----
    for (int k = 0; k < 11; k++) begin
      run_xfer(vecs[k].addr, vecs[k].wdata, vecs[k].wr, vecs[k].waits, vecs[k].sdata,
               vecs[k].serr, vecs[k].drop, 1'b1, onehot_idx(vecs[k].psel));
      check_xfer($sformatf("vec%0d", k), vecs[k].addr, vecs[k].wdata, vecs[k].wr,
                 vecs[k].lat, vecs[k].psel, vecs[k].err, vecs[k].rd, vecs[k].pen);
    end

    // ---- overlapping map: lowest index wins; reset during ACCESS drops transfer ----
    ov_m_paddr = 32'h1000_0000; ov_m_pwrite = 1'b0; ov_m_psel = 1'b1; ov_m_penable = 1'b0;
    step();
    check("ov_psel_setup", 32'(ov_s_psel), 32'h1);
    check("ov_penable_setup", 32'(ov_s_penable), 32'h0);
    ov_m_penable = 1'b1;
    step();
    check("ov_psel_access", 32'(ov_s_psel), 32'h1);
    check("ov_penable_access", 32'(ov_s_penable), 32'h1);
    ov_preset = 1'b1;
    step();
    check("ov_rst_psel", 32'(ov_s_psel), 32'h0);
    check("ov_rst_penable", 32'(ov_s_penable), 32'h0);
    check("ov_rst_pready", 32'(ov_m_pready), 32'h0);
    ov_preset = 1'b0;
    pulses = 0; sel_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ov_m_pready) pulses++;
      if (ov_s_psel != '0) sel_seen++;
    end
    check("ov_no_resp_after_rst", 32'(pulses), 32'h0);
    check("ov_no_psel_after_rst", 32'(sel_seen), 32'h0);
    ov_m_psel = 1'b0; ov_m_penable = 1'b0;

    // ---- randomized transfers against the reference model ----
    for (int k = 0; k < 40; k++) begin
      logic [31:0] addr, wdata, sdata;
      bit wr, serr, drop;
      int waits;
      addr  = {nibs[$urandom_range(0, 5)], 28'($urandom)};
      wdata = $urandom;
      sdata = $urandom;
      wr    = 1'($urandom_range(0, 1));
      serr  = 1'($urandom_range(0, 1));
      drop  = ($urandom_range(0, 7) == 0);
      waits = $urandom_range(0, 10);
      model(addr, wr, waits, sdata, serr, m_lat, m_psel_e, m_err, m_rd, m_pen);
      if ($urandom_range(0, 1) == 1) step();
      run_xfer(addr, wdata, wr, waits, sdata, serr, drop, 1'b1, onehot_idx(m_psel_e));
      check_xfer($sformatf("rnd%0d", k), addr, wdata, wr, m_lat, m_psel_e, m_err, m_rd, m_pen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
